// File: rtl/mem_access_pkg.sv
// Shared RV32I opcode/func3 codes, MEM-stage state encoding and low-address helpers.
package mem_access_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;

    // Load and store widths share encodings; SB/SH/SW alias LB/LH/LW.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } mem_state_e;

    // Undefined widths behave as word accesses.
    function automatic logic [1:0] force_align(input logic [2:0] func3, input logic [1:0] lo);
        case (func3)
            F3_B, F3_BU: force_align = lo;
            F3_H, F3_HU: force_align = {lo[1], 1'b0};
            default:     force_align = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] lo);
        case (func3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = lo[0];
            default:     is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_lane.sv
// mem_lane_align: combinational store lane replication/strobes and load shift/extend.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_st_func3,
    input  logic [1:0]      i_st_lo,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [2:0]      i_ld_func3,
    input  logic [1:0]      i_ld_lo,
    input  logic [XLEN-1:0] i_ld_rdata,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [15:0] w_half;

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_func3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_st_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            F3_H: begin
                o_wstrb = 4'b0011 << {i_st_lo[1], 1'b0};
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Only the addressed byte/half is ever needed after the shift.
    assign w_half = 16'(i_ld_rdata >> {i_ld_lo, 3'b000});

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_func3)
            F3_B:    o_ld_data = {{(XLEN-8){w_half[7]}}, w_half[7:0]};
            F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_half[7:0]};
            F3_H:    o_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: data-memory handshake, load extension, timeout. Define MEM_MISALIGN_TRAP_EN
// to trap misaligned half/word accesses instead of silently forcing the low address bits.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [4:0]      in_opcode,
    input  logic [2:0]      in_func3,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_flush,
    output logic            stall,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic            out_we,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_exc
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

    mem_state_e      r_state;
    logic [7:0]      r_cnt;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_func3;
    logic [4:0]      r_rd;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic            r_out_valid;
    logic            r_out_we;
    logic [4:0]      r_out_rd;
    logic [XLEN-1:0] r_out_data;
    logic            r_out_exc;

    logic            w_accept;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_trap;
    logic            w_timeout;
    logic [1:0]      w_st_lo;
    logic [1:0]      w_ld_lo;
    logic [3:0]      w_st_wstrb;
    logic [XLEN-1:0] w_st_wdata;
    logic [XLEN-1:0] w_ld_data;

    assign w_accept   = in_valid && !in_flush;
    assign w_is_load  = (in_opcode == OP_LOAD);
    assign w_is_store = (in_opcode == OP_STORE);
    assign w_st_lo    = force_align(in_func3, in_alu_out[1:0]);
    assign w_ld_lo    = force_align(r_func3, r_addr[1:0]);
    assign w_timeout  = (r_cnt == CntLast);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(in_func3, in_alu_out[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    mem_lane_align #(
        .XLEN(XLEN)
    ) u_lane (
        .i_st_func3 (in_func3),
        .i_st_lo    (w_st_lo),
        .i_st_data  (in_rs2),
        .i_ld_func3 (r_func3),
        .i_ld_lo    (w_ld_lo),
        .i_ld_rdata (mem_rdata),
        .o_wstrb    (w_st_wstrb),
        .o_wdata    (w_st_wdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_func3     <= 3'd0;
            r_rd        <= 5'd0;
            r_wstrb     <= 4'd0;
            r_wdata     <= '0;
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_data  <= '0;
            r_out_exc   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_out_rd <= in_rd;
                        if ((w_is_load || w_is_store) && w_trap) begin
                            r_out_valid <= 1'b1;
                            r_out_we    <= 1'b0;
                            r_out_data  <= in_alu_out;
                            r_out_exc   <= 1'b1;
                        end else if (w_is_load || w_is_store) begin
                            r_state <= StReq;
                            r_cnt   <= 8'd0;
                            r_we    <= w_is_store;
                            r_addr  <= in_alu_out;
                            r_func3 <= in_func3;
                            r_rd    <= in_rd;
                            r_wstrb <= w_is_store ? w_st_wstrb : 4'd0;
                            r_wdata <= w_is_store ? w_st_wdata : '0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_we    <= (in_rd != 5'd0) && (in_opcode != OP_BRANCH);
                            r_out_data  <= in_alu_out;
                            r_out_exc   <= 1'b0;
                        end
                    end
                end
                StReq, StWait: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A completing handshake wins over a coincident timeout.
                    if (r_state == StReq && mem_req_ready) begin
                        if (r_we) begin
                            r_state     <= StIdle;
                            r_out_valid <= 1'b1;
                            r_out_we    <= 1'b0;
                            r_out_rd    <= r_rd;
                            r_out_data  <= r_addr;
                            r_out_exc   <= 1'b0;
                        end else begin
                            r_state <= StWait;
                        end
                    end else if (r_state == StWait && mem_rsp_valid) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b1;
                        r_out_we    <= (r_rd != 5'd0);
                        r_out_rd    <= r_rd;
                        r_out_data  <= w_ld_data;
                        r_out_exc   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b1;
                        r_out_we    <= 1'b0;
                        r_out_rd    <= r_rd;
                        r_out_data  <= r_addr;
                        r_out_exc   <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign stall         = (r_state != StIdle);
    assign mem_req_valid = (r_state == StReq);
    assign mem_we        = r_we;
    assign mem_addr      = {r_addr[XLEN-1:2], 2'b00};
    assign mem_wstrb     = r_wstrb;
    assign mem_wdata     = r_wdata;
    assign out_valid     = r_out_valid;
    assign out_we        = r_out_we;
    assign out_rd        = r_out_rd;
    assign out_data      = r_out_data;
    assign out_exc       = r_out_exc;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expectations, a monitor pops on out_valid.
module tb_mem_access_stage;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_opcode = '0;
    logic [2:0]  in_func3 = '0;
    logic [31:0] in_alu_out = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_flush = 1'b0;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_exc;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_opcode     (in_opcode),
        .in_func3      (in_func3),
        .in_alu_out    (in_alu_out),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_flush      (in_flush),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_we        (out_we),
        .out_rd        (out_rd),
        .out_data      (out_data),
        .out_exc       (out_exc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input logic chk_data, input logic exc);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.chk_data = chk_data; e.exc = exc;
        return e;
    endfunction

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out_valid: got data %h exc %b, required no pulse",
                         out_data, out_exc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_we", {31'd0, out_we}, {31'd0, e.we});
                chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("out_exc", {31'd0, out_exc}, {31'd0, e.exc});
                if (e.chk_data) chk("out_data", out_data, e.data);
            end
        end
    end

    task automatic drive(input logic [4:0] opc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [4:0] rd);
        @(negedge clk);
        in_valid = 1'b1; in_opcode = opc; in_func3 = f3; in_alu_out = a; in_rs2 = rs2; in_rd = rd;
    endtask

    task automatic alu_op(input logic [4:0] opc, input logic [31:0] a, input logic [4:0] rd,
                          input logic exp_we);
        drive(opc, 3'd0, a, 32'h0, rd);
        sb.push_back(mk(exp_we, rd, a, 1'b1, 1'b0));
        chk("alu_stall_issue", {31'd0, stall}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("alu_stall_after", {31'd0, stall}, 32'd0);
        chk("alu_no_req", {31'd0, mem_req_valid}, 32'd0);
    endtask

    task automatic mem_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [4:0] rd, input int rdy_dly,
                          input int rsp_dly, input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_data);
        drive(st ? OPC_STORE : OPC_LOAD, f3, a, rs2, rd);
        if (st) sb.push_back(mk(1'b0, rd, 32'h0, 1'b0, 1'b0));
        else    sb.push_back(mk(rd != 5'd0, rd, e_data, 1'b1, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("req_we", {31'd0, mem_we}, {31'd0, st});
            chk("req_addr", mem_addr, e_addr);
            chk("req_wstrb", {28'd0, mem_wstrb}, {28'd0, e_strb});
            if (st) chk("req_wdata", mem_wdata, e_wdata);
            chk("req_stall", {31'd0, stall}, 32'd1);
            if (i == rdy_dly) mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
        end
        if (!st) begin
            for (int i = 0; i <= rsp_dly; i++) begin
                chk("wait_stall", {31'd0, stall}, 32'd1);
                chk("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
                if (i == rsp_dly) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
                mem_rsp_valid = 1'b0;
            end
        end
        chk("done_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory ops
        alu_op(OPC_OP, 32'h0000_1234, 5'd5, 1'b1);
        alu_op(OPC_JAL, 32'h0000_0408, 5'd1, 1'b1);
        alu_op(OPC_OP, 32'hCAFE_0001, 5'd0, 1'b0);
        alu_op(OPC_BRANCH, 32'h0000_0055, 5'd7, 1'b0);

        // Flushed op: no output, no stall
        drive(OPC_LOAD, 3'b010, 32'h0000_0300, 32'h0, 5'd9);
        in_flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_flush = 1'b0;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_no_req", {31'd0, mem_req_valid}, 32'd0);
        @(negedge clk);

        // Loads with byte/half extension
        mem_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF_FF7F, 32'h100, 4'h0, 32'h0,
               32'hFFFF_FF80);
        mem_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF_FF7F, 32'h100, 4'h0, 32'h0,
               32'h0000_0080);
        mem_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 0, 1, 32'h8001_0000, 32'h100, 4'h0, 32'h0,
               32'hFFFF_8001);
        mem_op(1'b0, 3'b101, 32'h102, 32'h0, 5'd8, 0, 0, 32'h8001_0000, 32'h100, 4'h0, 32'h0,
               32'h0000_8001);

        // Stores
        mem_op(1'b1, 3'b001, 32'h102, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0, 32'h100, 4'b1100,
               32'hBEEF_BEEF, 32'h0);
        mem_op(1'b1, 3'b000, 32'h202, 32'h1234_56AB, 5'd0, 1, 0, 32'h0, 32'h200, 4'b0100,
               32'hABAB_ABAB, 32'h0);
        mem_op(1'b1, 3'b010, 32'h204, 32'h0BAD_F00D, 5'd0, 0, 0, 32'h0, 32'h204, 4'b1111,
               32'h0BAD_F00D, 32'h0);

        // Back-pressured LW: ready low 3 cycles, response 2 cycles later
        mem_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd10, 3, 2, 32'h1122_3344, 32'h400, 4'h0, 32'h0,
               32'h1122_3344);

        // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
        drive(OPC_LOAD, 3'b010, 32'h101, 32'h0, 5'd4);
        sb.push_back(mk(1'b0, 5'd4, 32'h101, 1'b1, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("trap_no_req", {31'd0, mem_req_valid}, 32'd0);
        chk("trap_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
`else
        mem_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 0, 0, 32'hA5A5_1234, 32'h100, 4'h0, 32'h0,
               32'hA5A5_1234);
`endif

        // Timeout in WAIT
        drive(OPC_LOAD, 3'b010, 32'h200, 32'h0, 5'd3);
        sb.push_back(mk(1'b0, 5'd3, 32'h200, 1'b1, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        n = 0;
        while (stall && n < 400) begin
            n++;
            @(negedge clk);
            mem_req_ready = 1'b0;
        end
        chk("timeout_cycles", n, 32'd255);
        chk("timeout_no_req", {31'd0, mem_req_valid}, 32'd0);
        @(negedge clk);

        // Reset while waiting for a response, then a late response
        drive(OPC_LOAD, 3'b010, 32'hFFF0, 32'h0, 5'd12);
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_req", {31'd0, mem_req_valid}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_we", {31'd0, out_we}, 32'd0);
        chk("mid_rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_exc", {31'd0, out_exc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late_rsp_stall", {31'd0, stall}, 32'd0);
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
